mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for the single unified memory port of the MicroMIPS multicycle datapath. Shares the port between the CPU control section (instruction fetch and load/store states) and a DMA/loader requester. Holds each requester on a req/ack handshake, drives one single-word access at a time, tolerates memory wait states, and aborts hung accesses with an error response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CPU_STREAK_MAX, 4, consecutive CPU grants allowed while DMA waits; range 1..15
- TIMEOUT, 15, cycles to wait for mem_ready before abort; range 1..255

- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data; valid with cpu_ack, held until next CPU read ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ack: access timed out
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack, dma_err: same widths and meaning for the DMA port
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe, valid while mem_en
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  read data, sampled in the mem_ready cycle
- mem_ready  in  1  memory completed current access

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: mem_en=0. If any req: select winner; latch owner, we, addr, wdata into registers; clear timeout counter; next state BUSY. Otherwise stay.
- Selection: CPU wins by default. DMA wins if only dma_req is high, or if both are high and streak == CPU_STREAK_MAX.
- Streak counter: +1 on each CPU grant made while dma_req is high, saturating at CPU_STREAK_MAX. Cleared on DMA grant. Unchanged on a CPU grant with dma_req low.
- BUSY: mem_en=1; mem_we/addr/wdata driven from latched registers and ignore requester inputs. Timeout counter +1 per cycle.
  - mem_ready=1: for reads, capture mem_rdata into the owner's rdata register; err flag=0; next RESP.
  - Counter reaches TIMEOUT without mem_ready: err flag=1; owner rdata unchanged; next RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins, no error.
- RESP: mem_en=0. Pulse owner's ack for one cycle; err = latched flag. Next IDLE. The non-owner's ack is 0.
- Requester rules: req held with stable fields until ack. The requester drops req in the cycle after ack or presents a new request. A req deasserted before ack does not cancel the access; ack still pulses.
- mem_ready outside BUSY is ignored.
- Reset in any state: next state IDLE, latched access discarded, no ack issued, memory access abandoned.

## Timing
- Reset values: mem_en, mem_we, mem_addr, mem_wdata, both rdata, acks, errs, streak, timeout counter = 0; state IDLE.
- All outputs are registered or decoded from registered state. No combinational path from req or mem_ready to any output.
- req seen in IDLE at cycle 0:
  - mem_en high from cycle 1.
  - mem_ready at cycle k (k≥1) gives ack at cycle k+1.
  - Zero-wait turnaround is 3 cycles (IDLE, BUSY, RESP).
- Back-to-back: a req held through RESP is arbitrated in the following IDLE cycle.
- Timeout: with no mem_ready, mem_en is high for exactly TIMEOUT cycles and ack+err follow in the next cycle.
- Throughput: one access per 3+wait cycles. No overlap of accesses.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, BUSY, RESP}
  - owner constants OWNER_CPU=0, OWNER_DMA=1
  - width helper for the counters
- One sub-module mem_arb_timer: loadable up-counter with clear, enable, and terminal-count output. It serves the timeout counter and, instantiated a second time, the saturating streak counter.
- Everything else (FSM, latches, output muxing) lives in the top module.

## Test plan
- CPU read, zero wait: cpu_req, addr 0x40, mem_ready=1 in first BUSY cycle, mem_rdata 0xDEADBEEF -> mem_en high 1 cycle; cpu_ack at cycle 3 with cpu_rdata=0xDEADBEEF, cpu_err=0.
- DMA write, 2 wait states: dma_we=1, addr 0x10, wdata 0x1234 -> mem_we=1 and mem_addr=0x10 for 3 cycles; dma_ack 1 cycle after mem_ready; cpu_ack stays 0.
- Starvation limit: both req held continuously, CPU_STREAK_MAX=4, zero wait -> grant order CPU,CPU,CPU,CPU,DMA,CPU…
- Timeout: CPU read, mem_ready never asserted, TIMEOUT=15 -> mem_en high 15 cycles; cpu_ack+cpu_err at next cycle; cpu_rdata keeps its previous value.
- Ready/timeout collision: mem_ready in the 15th BUSY cycle -> ack with err=0 and data captured.
- Reset mid-access: reset in the 2nd BUSY cycle -> next cycle mem_en=0, no ack, all outputs 0. A subsequent request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Bits needed for a counter that must be able to hold max_value.
    function automatic int counter_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// rtl/mem_arb_timer.sv - loadable up-counter with clear, enable and terminal-count flag
module mem_arb_timer
    import mem_arb_pkg::*;
#(
    parameter int W        = 4,
    parameter int TERMINAL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         tc
);

    localparam logic [W-1:0] TERM = W'(TERMINAL);

    logic [W-1:0] count;

    // Count register: clear has priority over load, load over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter and sequencer for the unified memory port
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CPU_STREAK_MAX = 4,
    parameter int TIMEOUT        = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int TO_W = counter_width(TIMEOUT);
    localparam int SK_W = counter_width(CPU_STREAK_MAX);

    state_t            state_q;
    state_t            state_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic is_idle;
    logic is_busy;
    logic is_resp;
    logic grant;
    logic dma_wins;
    logic streak_tc;
    logic timeout_tc;

    assign is_idle  = (state_q == IDLE);
    assign is_busy  = (state_q == BUSY);
    assign is_resp  = (state_q == RESP);
    assign grant    = is_idle && (cpu_req || dma_req);
    // CPU is favoured unless it has already taken its quota of grants past a waiting DMA.
    assign dma_wins = dma_req && (!cpu_req || streak_tc);

    // Timeout counter: restarts at each grant, advances once per BUSY cycle.
    // Terminal at TIMEOUT-1 marks the last BUSY cycle allowed.
    mem_arb_timer #(
        .W        (TO_W),
        .TERMINAL (TIMEOUT - 1)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .clear      (grant),
        .load       (1'b0),
        .load_value ('0),
        .enable     (is_busy),
        .tc         (timeout_tc)
    );

    // Streak counter: counts CPU grants that overtook a pending DMA, saturating at the quota.
    mem_arb_timer #(
        .W        (SK_W),
        .TERMINAL (CPU_STREAK_MAX)
    ) u_streak (
        .clk        (clk),
        .reset      (reset),
        .clear      (grant && dma_wins),
        .load       (1'b0),
        .load_value ('0),
        .enable     (grant && !dma_wins && dma_req && !streak_tc),
        .tc         (streak_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ready beats timeout when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (mem_ready || timeout_tc) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access latches, error flag and per-requester read data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWNER_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (grant) begin
                owner_q <= dma_wins ? OWNER_DMA : OWNER_CPU;
                we_q    <= dma_wins ? dma_we    : cpu_we;
                addr_q  <= dma_wins ? dma_addr  : cpu_addr;
                wdata_q <= dma_wins ? dma_wdata : cpu_wdata;
            end
            if (is_busy && mem_ready) begin
                err_q <= 1'b0;
                if (!we_q) begin
                    if (owner_q == OWNER_DMA) begin
                        dma_rdata_q <= mem_rdata;
                    end else begin
                        cpu_rdata_q <= mem_rdata;
                    end
                end
            end else if (is_busy && timeout_tc) begin
                err_q <= 1'b1;
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        mem_en    = is_busy;
        mem_we    = is_busy && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = is_resp && (owner_q == OWNER_CPU);
        dma_ack   = is_resp && (owner_q == OWNER_DMA);
        cpu_err   = is_resp && (owner_q == OWNER_CPU) && err_q;
        dma_err   = is_resp && (owner_q == OWNER_DMA) && err_q;
        cpu_rdata = cpu_rdata_q;
        dma_rdata = dma_rdata_q;
    end

endmodule
